// File: rtl/arbitro_escritura_banco.sv
// rtl/arbitro_escritura_banco.sv - register bank write-back arbiter with pending-write scoreboard
module arbitro_escritura_banco #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5,
  parameter int ANCHO_CONT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  congelar,
  input  logic                  req_alu,
  input  logic [ANCHO_DIR-1:0]  dir_alu,
  input  logic [ANCHO_DATO-1:0] dato_alu,
  output logic                  listo_alu,
  input  logic                  req_mem,
  input  logic [ANCHO_DIR-1:0]  dir_mem,
  input  logic [ANCHO_DATO-1:0] dato_mem,
  output logic                  listo_mem,
  input  logic                  reserva_valida,
  input  logic [ANCHO_DIR-1:0]  reserva_dir,
  input  logic [ANCHO_DIR-1:0]  consulta_1,
  input  logic [ANCHO_DIR-1:0]  consulta_2,
  output logic                  ocupado_1,
  output logic                  ocupado_2,
  output logic                  w_r,
  output logic [ANCHO_DIR-1:0]  direccion,
  output logic [ANCHO_DATO-1:0] dato,
  output logic [ANCHO_CONT-1:0] contador_escrituras
);

  localparam int PROFUNDIDAD = 2 ** ANCHO_DIR;

  logic                   prio_mem;
  logic                   aceptado;
  logic                   contienda;
  logic [ANCHO_DIR-1:0]   dir_sel;
  logic [ANCHO_DATO-1:0]  dato_sel;
  logic [PROFUNDIDAD-1:0] marcas;
  logic [PROFUNDIDAD-1:0] marcas_sig;

  // prio_mem names the side that wins the next contested cycle
  always_comb begin
    listo_alu = 1'b0;
    listo_mem = 1'b0;
    if (!congelar) begin
      if (req_alu && req_mem) begin
        listo_mem = prio_mem;
        listo_alu = !prio_mem;
      end else begin
        listo_alu = req_alu;
        listo_mem = req_mem;
      end
    end
  end

  assign aceptado  = listo_alu || listo_mem;
  assign contienda = req_alu && req_mem && !congelar;
  assign dir_sel   = listo_mem ? dir_mem : dir_alu;
  assign dato_sel  = listo_mem ? dato_mem : dato_alu;

  // Reservation is applied after the clear so it wins on the same address
  always_comb begin
    marcas_sig = marcas;
    if (aceptado) begin
      marcas_sig[dir_sel] = 1'b0;
    end
    if (reserva_valida) begin
      marcas_sig[reserva_dir] = 1'b1;
    end
  end

  assign ocupado_1 = marcas[consulta_1];
  assign ocupado_2 = marcas[consulta_2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r                 <= 1'b1;
      direccion           <= '0;
      dato                <= '0;
      marcas              <= '0;
      contador_escrituras <= '0;
      prio_mem            <= 1'b1;
    end else begin
      w_r    <= !aceptado;
      marcas <= marcas_sig;
      if (aceptado) begin
        direccion           <= dir_sel;
        dato                <= dato_sel;
        contador_escrituras <= contador_escrituras + ANCHO_CONT'(1);
      end
      if (contienda) begin
        prio_mem <= !prio_mem;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// tb/tb_arbitro_escritura_banco.sv - directed self-checking bench for arbitro_escritura_banco
module tb_arbitro_escritura_banco;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        congelar;
  logic        req_alu;
  logic [4:0]  dir_alu;
  logic [31:0] dato_alu;
  logic        listo_alu;
  logic        req_mem;
  logic [4:0]  dir_mem;
  logic [31:0] dato_mem;
  logic        listo_mem;
  logic        reserva_valida;
  logic [4:0]  reserva_dir;
  logic [4:0]  consulta_1;
  logic [4:0]  consulta_2;
  logic        ocupado_1;
  logic        ocupado_2;
  logic        w_r;
  logic [4:0]  direccion;
  logic [31:0] dato;
  logic [15:0] contador_escrituras;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbitro_escritura_banco dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .congelar            (congelar),
    .req_alu             (req_alu),
    .dir_alu             (dir_alu),
    .dato_alu            (dato_alu),
    .listo_alu           (listo_alu),
    .req_mem             (req_mem),
    .dir_mem             (dir_mem),
    .dato_mem            (dato_mem),
    .listo_mem           (listo_mem),
    .reserva_valida      (reserva_valida),
    .reserva_dir         (reserva_dir),
    .consulta_1          (consulta_1),
    .consulta_2          (consulta_2),
    .ocupado_1           (ocupado_1),
    .ocupado_2           (ocupado_2),
    .w_r                 (w_r),
    .direccion           (direccion),
    .dato                (dato),
    .contador_escrituras (contador_escrituras)
  );

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    congelar = 1'b0;
    req_alu = 1'b0; dir_alu = '0; dato_alu = '0;
    req_mem = 1'b0; dir_mem = '0; dato_mem = '0;
    reserva_valida = 1'b0; reserva_dir = '0;
    consulta_1 = '0; consulta_2 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chequear("reset_w_r", 32'(w_r), 32'd1);
    chequear("reset_direccion", 32'(direccion), 32'd0);
    chequear("reset_dato", dato, 32'd0);
    chequear("reset_ocupado_1", 32'(ocupado_1), 32'd0);
    chequear("reset_ocupado_2", 32'(ocupado_2), 32'd0);
    chequear("reset_contador", 32'(contador_escrituras), 32'd0);

    // Single ALU write
    req_alu = 1'b1; dir_alu = 5'd5; dato_alu = 32'h1234;
    #1;
    chequear("alu_solo_listo_alu", 32'(listo_alu), 32'd1);
    chequear("alu_solo_listo_mem", 32'(listo_mem), 32'd0);
    tick();
    req_alu = 1'b0;
    chequear("alu_solo_w_r", 32'(w_r), 32'd0);
    chequear("alu_solo_direccion", 32'(direccion), 32'd5);
    chequear("alu_solo_dato", dato, 32'h1234);
    chequear("alu_solo_contador", 32'(contador_escrituras), 32'd1);
    tick();
    chequear("alu_solo_w_r_fin", 32'(w_r), 32'd1);

    // Contested round-robin: MEM, ALU, MEM, ALU
    req_alu = 1'b1; dir_alu = 5'd7; dato_alu = 32'hA7A7;
    req_mem = 1'b1; dir_mem = 5'd9; dato_mem = 32'hB9B9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chequear("rr_listo_mem", 32'(listo_mem), (i % 2 == 0) ? 32'd1 : 32'd0);
      chequear("rr_listo_alu", 32'(listo_alu), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      if (i == 3) begin
        req_alu = 1'b0; req_mem = 1'b0;
      end
      chequear("rr_w_r", 32'(w_r), 32'd0);
      chequear("rr_direccion", 32'(direccion), (i % 2 == 0) ? 32'd9 : 32'd7);
      chequear("rr_dato", dato, (i % 2 == 0) ? 32'hB9B9 : 32'hA7A7);
    end
    tick();
    chequear("rr_w_r_fin", 32'(w_r), 32'd1);
    chequear("rr_contador", 32'(contador_escrituras), 32'd5);

    // Scoreboard
    reserva_valida = 1'b1; reserva_dir = 5'd8; consulta_1 = 5'd8; consulta_2 = 5'd9;
    #1;
    chequear("sb_sin_bypass", 32'(ocupado_1), 32'd0);
    tick();
    reserva_valida = 1'b0;
    chequear("sb_reservado", 32'(ocupado_1), 32'd1);
    chequear("sb_otro_libre", 32'(ocupado_2), 32'd0);
    req_mem = 1'b1; dir_mem = 5'd8; dato_mem = 32'h88;
    #1;
    chequear("sb_listo_mem", 32'(listo_mem), 32'd1);
    chequear("sb_aun_ocupado", 32'(ocupado_1), 32'd1);
    tick();
    req_mem = 1'b0;
    chequear("sb_liberado", 32'(ocupado_1), 32'd0);
    reserva_valida = 1'b1; reserva_dir = 5'd8;
    req_alu = 1'b1; dir_alu = 5'd8; dato_alu = 32'h99;
    tick();
    reserva_valida = 1'b0; req_alu = 1'b0;
    chequear("sb_reserva_gana", 32'(ocupado_1), 32'd1);
    req_alu = 1'b1; dir_alu = 5'd8;
    tick();
    req_alu = 1'b0;
    chequear("sb_liberado_2", 32'(ocupado_1), 32'd0);
    tick();

    // Freeze: an issued write still completes, no new grants, reservations still land
    req_mem = 1'b1; dir_mem = 5'd3; dato_mem = 32'h33;
    tick();
    req_mem = 1'b0;
    congelar = 1'b1;
    chequear("cg_escritura_en_curso", 32'(w_r), 32'd0);
    req_mem = 1'b1; dir_mem = 5'd4; dato_mem = 32'h44;
    reserva_valida = 1'b1; reserva_dir = 5'd4; consulta_2 = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chequear("cg_listo_mem", 32'(listo_mem), 32'd0);
      tick();
      reserva_valida = 1'b0;
      chequear("cg_w_r", 32'(w_r), 32'd1);
    end
    chequear("cg_reserva", 32'(ocupado_2), 32'd1);
    chequear("cg_contador", 32'(contador_escrituras), 32'd9);
    congelar = 1'b0;
    #1;
    chequear("cg_listo_liberado", 32'(listo_mem), 32'd1);
    tick();
    req_mem = 1'b0;
    chequear("cg_w_r_liberado", 32'(w_r), 32'd0);
    chequear("cg_direccion", 32'(direccion), 32'd4);
    chequear("cg_libera_r4", 32'(ocupado_2), 32'd0);

    // Async reset in the middle of an issued write
    reserva_valida = 1'b1; reserva_dir = 5'd4;
    req_alu = 1'b1; dir_alu = 5'd1; dato_alu = 32'h11;
    tick();
    reserva_valida = 1'b0; req_alu = 1'b0;
    chequear("rst_pre_w_r", 32'(w_r), 32'd0);
    chequear("rst_pre_ocupado", 32'(ocupado_2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chequear("rst_async_w_r", 32'(w_r), 32'd1);
    chequear("rst_async_ocupado", 32'(ocupado_2), 32'd0);
    chequear("rst_async_contador", 32'(contador_escrituras), 32'd0);
    tick();
    rst_n = 1'b1;

    // Counter wrap; register 0 is writable
    req_alu = 1'b1; dir_alu = 5'd0; dato_alu = 32'hC0;
    repeat (65535) @(posedge clk);
    #1;
    chequear("wrap_ffff", 32'(contador_escrituras), 32'hFFFF);
    chequear("wrap_dir0", 32'(direccion), 32'd0);
    tick();
    req_alu = 1'b0;
    chequear("wrap_cero", 32'(contador_escrituras), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
